// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control, LUT-write and PC status bundle of the program-counter sequencer.
// Ports (master drives, slave consumes):
//   start, stall, halt        sequencer control
//   instruction, branch, zero  branch decision; instruction[LUT_AW-1:0] indexes the target LUT
//   lut_we, lut_waddr, lut_wdata  branch-target LUT write port
//   pc, pc_valid, taken, halted   sequencer status (driven by the slave)
interface pc_sequencer_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 9,
    parameter int LUT_AW  = 4
);
    logic               start;
    logic               stall;
    logic               halt;
    logic [INSTR_W-1:0] instruction;
    logic               branch;
    logic               zero;
    logic               lut_we;
    logic [LUT_AW-1:0]  lut_waddr;
    logic [PC_W-1:0]    lut_wdata;
    logic [PC_W-1:0]    pc;
    logic               pc_valid;
    logic               taken;
    logic               halted;

    modport master (
        output start, stall, halt, instruction, branch, zero, lut_we, lut_waddr, lut_wdata,
        input  pc, pc_valid, taken, halted
    );

    modport slave (
        input  start, stall, halt, instruction, branch, zero, lut_we, lut_waddr, lut_wdata,
        output pc, pc_valid, taken, halted
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with stall, sticky halt and LUT-based conditional branches.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (pc=RESET_PC, IDLE, taken=0)
//   bus    pc_sequencer_if.slave: control/branch inputs, LUT write port, pc/pc_valid/taken/halted
module pc_sequencer #(
    parameter int PC_W     = 32,
    parameter int INSTR_W  = 9,
    parameter int PC_STEP  = 4,
    parameter int LUT_AW   = 4,
    parameter int REL_MODE = 0,
    parameter int RESET_PC = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_sequencer_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            taken_q, taken_d;
    logic [PC_W-1:0] lut_q [2**LUT_AW];
    logic [PC_W-1:0] entry;
    logic [PC_W-1:0] target;

    // Asynchronous read sees the pre-write entry, so a same-cycle write is visible only next cycle.
    assign entry  = lut_q[bus.instruction[LUT_AW-1:0]];
    assign target = (REL_MODE != 0) ? pc_q + entry : entry;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = taken_q;
        case (state_q)
            IDLE: state_d = bus.start ? RUN : IDLE;
            RUN: begin
                if (bus.halt) begin
                    state_d = HALT;
                    taken_d = 1'b0;
                end else if (!bus.stall) begin
                    pc_d    = (bus.branch && bus.zero) ? target : pc_q + PC_W'(PC_STEP);
                    taken_d = bus.branch && bus.zero;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= PC_W'(RESET_PC);
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
        end
    end

    // LUT is deliberately not reset; writes are accepted in every state.
    always_ff @(posedge clk) begin
        if (bus.lut_we) lut_q[bus.lut_waddr] <= bus.lut_wdata;
    end

    assign bus.pc       = pc_q;
    assign bus.pc_valid = (state_q == RUN);
    assign bus.taken    = taken_q;
    assign bus.halted   = (state_q == HALT);
endmodule
